pid_loop_sequencer: RTL and testbench
=====================================

Name: pid_loop_sequencer

Overview:
Sequences one control iteration of the PSU PID loop on a fixed sample period. Each iteration runs in this order: ADC conversion request, capture of the measured voltage, error-calculation strobe to the error stage, PID compute handshake, then a DAC/PWM load pulse. It sits between the SPI ADC front end, the error stage (driven with calc_error/cur_vd), the PID arithmetic and the output driver. It also reports overruns and ADC timeouts.

Parameters:
ADC_WIDTH, 8, width of ADC sample and cur_vd
PERIOD_CYCLES, 1000, clk cycles per loop iteration (>= 8)
ADC_TIMEOUT, 256, max cycles waiting for adc_done before abort (>= 2)
CNT_WIDTH, 16, width of sample_count

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
enable  input  1  run loop; low stops new iterations
clr_flags  input  1  clears overrun and adc_timeout
adc_start  output  1  one-cycle conversion request
adc_done  input  1  conversion complete, qualifies adc_data
adc_data  input  ADC_WIDTH  converted sample
cur_vd  output  ADC_WIDTH  registered latest valid sample
calc_error  output  1  one-cycle strobe to error stage
pid_start  output  1  one-cycle PID compute request
pid_done  input  1  PID result ready
dac_load  output  1  one-cycle output-register load
busy  output  1  high in any state other than IDLE
overrun  output  1  sticky: tick arrived while busy
adc_timeout  output  1  sticky: ADC did not respond in time
sample_count  output  CNT_WIDTH  completed iterations, wraps

Behaviour:
- Reset (sync, rst=1 at edge): state IDLE; period counter 0; cur_vd 0; sample_count 0; all pulses, busy, overrun and adc_timeout 0. Applying rst mid-iteration aborts it with no further pulses.
- Period counter: counts 0..PERIOD_CYCLES-1 while enable=1, then wraps. tick = 1 for the single cycle in which the counter equals PERIOD_CYCLES-1. While enable=0 the counter is held at 0 and there is no tick.
- States: IDLE, ADC_REQ, ADC_WAIT, ERR, PID_REQ, PID_WAIT, DAC.
- IDLE: on tick, go to ADC_REQ.
- ADC_REQ: adc_start=1 for this one cycle, then go to ADC_WAIT. adc_done during ADC_REQ is ignored. The timeout counter clears here.
- ADC_WAIT: if adc_done=1, load cur_vd<=adc_data on that edge and go to ERR. Otherwise increment the timeout counter. When it reaches ADC_TIMEOUT, set adc_timeout, return to IDLE, leave cur_vd unchanged and issue no calc_error.
- ERR: calc_error=1 for one cycle, with cur_vd already stable. Go to PID_REQ. The error stage's registered diff is valid from the next cycle.
- PID_REQ: pid_start=1 for one cycle, then go to PID_WAIT. pid_done is ignored in PID_REQ.
- PID_WAIT: on pid_done=1, go to DAC. There is no timeout here.
- DAC: dac_load=1 for one cycle; sample_count+1 (wraps at 2^CNT_WIDTH); return to IDLE.
- Nominal latency: adc_start in cycle T+1 after tick cycle T. calc_error comes 1 cycle after adc_done is sampled, pid_start 1 cycle after calc_error, and dac_load 1 cycle after pid_done is sampled.
- Overrun: a tick while state != IDLE sets overrun and is dropped, never queued. The tick in the same cycle that DAC returns to IDLE is also dropped and counted as an overrun.
- enable deassert mid-iteration: the current iteration completes normally; no new iteration starts.
- clr_flags clears both sticky flags. If a set event and clr_flags occur in the same cycle, the set wins.
- All outputs are registered; pulses never exceed one cycle.

Test Plan:
- PERIOD_CYCLES=20, enable at cycle 0, ADC responds adc_data=0x5A after 3 cycles, pid_done 4 cycles after pid_start -> adc_start at cycle 20; cur_vd=0x5A on the calc_error cycle; pid_start the next cycle; one dac_load; sample_count=1; busy low before cycle 40.
- ADC_TIMEOUT=8, adc_done never asserted -> adc_timeout=1 at 8 cycles after adc_start; no calc_error/pid_start/dac_load; cur_vd unchanged; next tick starts a new iteration normally.
- pid_done held off 30 cycles with PERIOD_CYCLES=20 -> overrun=1 at the tick during PID_WAIT; exactly one dac_load; the following iteration starts at the first tick after return to IDLE.
- clr_flags asserted in the same cycle as a new overrun tick -> overrun remains 1. clr_flags alone the next cycle -> overrun=0.
- rst asserted in ADC_WAIT with adc_done arriving the same cycle -> cur_vd=0, no calc_error, state IDLE, counters 0.
- enable dropped one cycle after adc_start -> iteration finishes with dac_load; no further adc_start for 3×PERIOD_CYCLES.

Source files
------------

// File: rtl/pid_loop_sequencer_if.sv
// Handshake bundle between the loop sequencer and its neighbours:
// the SPI ADC front end, the error stage, the PID arithmetic and the
// output driver. The sequencer side uses the master modport.
interface pid_loop_sequencer_if #(
  parameter int ADC_WIDTH = 8
);
  logic                 adc_start;
  logic                 adc_done;
  logic [ADC_WIDTH-1:0] adc_data;
  logic [ADC_WIDTH-1:0] cur_vd;
  logic                 calc_error;
  logic                 pid_start;
  logic                 pid_done;
  logic                 dac_load;

  modport master (
    output adc_start, cur_vd, calc_error, pid_start, dac_load,
    input  adc_done, adc_data, pid_done
  );

  modport slave (
    input  adc_start, cur_vd, calc_error, pid_start, dac_load,
    output adc_done, adc_data, pid_done
  );
endinterface

// File: rtl/pid_loop_sequencer.sv
// PID loop sequencer: on every sample-period tick runs one control
// iteration (ADC request, sample capture, error strobe, PID handshake,
// DAC/PWM load) and flags overruns and ADC timeouts. All outputs are
// registered; pulse outputs are computed from the next state so that
// each one is high exactly while the FSM sits in the matching state.
module pid_loop_sequencer #(
  parameter int ADC_WIDTH     = 8,
  parameter int PERIOD_CYCLES = 1000,
  parameter int ADC_TIMEOUT   = 256,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 clr_flags,
  pid_loop_sequencer_if.master bus,
  output logic                 busy,
  output logic                 overrun,
  output logic                 adc_timeout,
  output logic [CNT_WIDTH-1:0] sample_count
);

  localparam int PW = $clog2(PERIOD_CYCLES);
  localparam int TW = $clog2(ADC_TIMEOUT);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD_CYCLES - 1);
  // The wait counter starts at 0 in the first ADC_WAIT cycle; aborting
  // on value ADC_TIMEOUT-2 makes the flag appear exactly ADC_TIMEOUT
  // cycles after the adc_start pulse.
  localparam logic [TW-1:0] WAIT_LAST = TW'(ADC_TIMEOUT - 2);

  typedef enum logic [2:0] {
    IDLE, ADC_REQ, ADC_WAIT, ERR, PID_REQ, PID_WAIT, DAC
  } state_t;

  state_t               state;
  state_t               next_state;
  logic [PW-1:0]        period_cnt;
  logic [TW-1:0]        wait_cnt;
  logic                 tick;
  logic                 capture;
  logic                 timeout_hit;
  logic [ADC_WIDTH-1:0] sample_in;

  assign tick      = enable && (period_cnt == PERIOD_LAST);
  assign sample_in = bus.adc_data;

  // Sample-period counter, parked at zero while the loop is disabled.
  always_ff @(posedge clk) begin
    if (rst || !enable || tick) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + PW'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic plus the capture and timeout decisions.
  always_comb begin
    next_state  = state;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE:     if (tick) next_state = ADC_REQ;
      ADC_REQ:  next_state = ADC_WAIT;
      ADC_WAIT: begin
        if (bus.adc_done) begin
          capture    = 1'b1;
          next_state = ERR;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout_hit = 1'b1;
          next_state  = IDLE;
        end
      end
      ERR:      next_state = PID_REQ;
      PID_REQ:  next_state = PID_WAIT;
      PID_WAIT: if (bus.pid_done) next_state = DAC;
      DAC:      next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // ADC wait counter, cleared while the conversion request is out.
  always_ff @(posedge clk) begin
    if (rst || state == ADC_REQ) begin
      wait_cnt <= '0;
    end else if (state == ADC_WAIT) begin
      wait_cnt <= wait_cnt + TW'(1);
    end
  end

  // Registered pulses, busy, captured sample and iteration count.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.adc_start  <= 1'b0;
      bus.calc_error <= 1'b0;
      bus.pid_start  <= 1'b0;
      bus.dac_load   <= 1'b0;
      bus.cur_vd     <= '0;
      busy           <= 1'b0;
      sample_count   <= '0;
    end else begin
      bus.adc_start  <= (next_state == ADC_REQ);
      bus.calc_error <= (next_state == ERR);
      bus.pid_start  <= (next_state == PID_REQ);
      bus.dac_load   <= (next_state == DAC);
      busy           <= (next_state != IDLE);
      if (capture) begin
        bus.cur_vd <= sample_in;
      end
      if (next_state == DAC) begin
        sample_count <= sample_count + CNT_WIDTH'(1);
      end
    end
  end

  // Sticky status flags; a new event beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun     <= 1'b0;
      adc_timeout <= 1'b0;
    end else begin
      if (tick && state != IDLE) begin
        overrun <= 1'b1;
      end else if (clr_flags) begin
        overrun <= 1'b0;
      end
      if (timeout_hit) begin
        adc_timeout <= 1'b1;
      end else if (clr_flags) begin
        adc_timeout <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pid_loop_sequencer.sv
// Self-checking bench for pid_loop_sequencer. Responders answer the
// ADC and PID handshakes after configurable delays and push the
// expected calc_error / pid_start / dac_load timing, captured sample
// and iteration count into scoreboard queues that are popped when the
// DUT produces the corresponding pulse.
module tb_pid_loop_sequencer;

  localparam int ADC_WIDTH = 8;
  localparam int PERIOD    = 20;
  localparam int TIMEOUT   = 8;
  localparam int CNT_WIDTH = 16;

  logic                 clk;
  logic                 rst;
  logic                 enable;
  logic                 clr_flags;
  logic                 busy;
  logic                 overrun;
  logic                 adc_timeout;
  logic [CNT_WIDTH-1:0] sample_count;

  pid_loop_sequencer_if #(.ADC_WIDTH(ADC_WIDTH)) bus ();

  pid_loop_sequencer #(
    .ADC_WIDTH    (ADC_WIDTH),
    .PERIOD_CYCLES(PERIOD),
    .ADC_TIMEOUT  (TIMEOUT),
    .CNT_WIDTH    (CNT_WIDTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .clr_flags   (clr_flags),
    .bus         (bus),
    .busy        (busy),
    .overrun     (overrun),
    .adc_timeout (adc_timeout),
    .sample_count(sample_count)
  );

  int n_compared   = 0;
  int n_mismatched = 0;
  int cyc          = 0;
  int c0           = 0;
  int adc_delay    = 3;
  int pid_delay    = 4;
  int adc_due      = -1;
  int pid_due      = -1;
  logic [7:0] next_value = 8'h5A;
  int n_start, n_calc, n_pid, n_dac;
  int start_cycles[$];
  int exp_calc_cyc[$];
  logic [7:0] exp_vd[$];
  int exp_pid_cyc[$];
  int exp_dac_cyc[$];
  int exp_cnt[$];
  int model_count;
  bit cnt_pending;
  int cnt_expected;

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
    end
  endtask

  task automatic flush_model();
    exp_calc_cyc.delete();
    exp_vd.delete();
    exp_pid_cyc.delete();
    exp_dac_cyc.delete();
    exp_cnt.delete();
    start_cycles.delete();
    model_count = 0;
    cnt_pending = 0;
    adc_due     = -1;
    pid_due     = -1;
    n_start = 0; n_calc = 0; n_pid = 0; n_dac = 0;
  endtask

  task automatic observe();
    if (cnt_pending) begin
      checkOutput("count_after_dac", sample_count, cnt_expected);
      cnt_pending = 0;
    end
    if (bus.adc_start === 1'b1) begin
      n_start++;
      start_cycles.push_back(cyc - c0);
      adc_due = (adc_delay > 0) ? cyc + adc_delay : -1;
    end
    if (bus.calc_error === 1'b1) begin
      n_calc++;
      if (exp_calc_cyc.size() == 0) begin
        checkOutput("calc_unexpected", bus.calc_error, 0);
      end else begin
        checkOutput("calc_cycle", cyc - c0, exp_calc_cyc.pop_front() - c0);
        checkOutput("cur_vd_at_calc", bus.cur_vd, exp_vd.pop_front());
        exp_pid_cyc.push_back(cyc + 1);
      end
    end
    if (bus.pid_start === 1'b1) begin
      n_pid++;
      pid_due = cyc + pid_delay;
      if (exp_pid_cyc.size() == 0) begin
        checkOutput("pid_unexpected", bus.pid_start, 0);
      end else begin
        checkOutput("pid_start_cycle", cyc - c0, exp_pid_cyc.pop_front() - c0);
      end
    end
    if (bus.dac_load === 1'b1) begin
      n_dac++;
      if (exp_dac_cyc.size() == 0) begin
        checkOutput("dac_unexpected", bus.dac_load, 0);
      end else begin
        checkOutput("dac_cycle", cyc - c0, exp_dac_cyc.pop_front() - c0);
        cnt_expected = exp_cnt.pop_front();
        cnt_pending  = 1;
      end
    end
  endtask

  task automatic respond();
    bus.adc_done = 1'b0;
    bus.pid_done = 1'b0;
    bus.adc_data = 8'($urandom);
    if (cyc == adc_due) begin
      bus.adc_done = 1'b1;
      bus.adc_data = next_value;
      exp_calc_cyc.push_back(cyc + 1);
      exp_vd.push_back(next_value);
      next_value = 8'($urandom_range(1, 255));
      adc_due = -1;
    end
    if (cyc == pid_due) begin
      bus.pid_done = 1'b1;
      model_count++;
      exp_dac_cyc.push_back(cyc + 1);
      exp_cnt.push_back(model_count % (1 << CNT_WIDTH));
      pid_due = -1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    observe();
    respond();
  endtask

  task automatic run_until(input int rel);
    while (cyc < c0 + rel) step();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    enable    = 1'b0;
    clr_flags = 1'b0;
    step();
    step();
    flush_model();
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input int adc_dly, input int pid_dly,
                               input logic [7:0] first_value);
    adc_delay  = adc_dly;
    pid_delay  = pid_dly;
    next_value = first_value;
    enable     = 1'b1;
    c0         = cyc;
  endtask

  task automatic check_drained(input string tag);
    checkOutput({tag, "_calc_pending"}, exp_calc_cyc.size(), 0);
    checkOutput({tag, "_pid_pending"}, exp_pid_cyc.size(), 0);
    checkOutput({tag, "_dac_pending"}, exp_dac_cyc.size(), 0);
  endtask

  task automatic check_starts(input string tag, input int a, input int b, input int c);
    int want[$];
    want.push_back(a);
    if (b >= 0) want.push_back(b);
    if (c >= 0) want.push_back(c);
    checkOutput({tag, "_start_count"}, start_cycles.size(), want.size());
    for (int i = 0; i < want.size() && i < start_cycles.size(); i++) begin
      checkOutput({tag, "_start_cycle"}, start_cycles[i], want[i]);
    end
  endtask

  // Scenario sequence and final summary.
  initial begin
    rst          = 1'b1;
    enable       = 1'b0;
    clr_flags    = 1'b0;
    bus.adc_done = 1'b0;
    bus.pid_done = 1'b0;
    bus.adc_data = '0;
    flush_model();
    do_reset();

    $display("[TB] reset state");
    checkOutput("rst_adc_start", bus.adc_start, 0);
    checkOutput("rst_calc_error", bus.calc_error, 0);
    checkOutput("rst_pid_start", bus.pid_start, 0);
    checkOutput("rst_dac_load", bus.dac_load, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_overrun", overrun, 0);
    checkOutput("rst_adc_timeout", adc_timeout, 0);
    checkOutput("rst_cur_vd", bus.cur_vd, 0);
    checkOutput("rst_sample_count", sample_count, 0);

    $display("[TB] nominal iterations");
    applyStimulus(3, 4, 8'h5A);
    run_until(19);
    checkOutput("A_no_early_start", n_start, 0);
    run_until(20);
    checkOutput("A_adc_start_t20", bus.adc_start, 1);
    run_until(30);
    checkOutput("A_busy_in_dac", busy, 1);
    checkOutput("A_dac_t30", bus.dac_load, 1);
    run_until(31);
    checkOutput("A_busy_low", busy, 0);
    checkOutput("A_count1", sample_count, 1);
    run_until(75);
    check_starts("A", 20, 40, 60);
    checkOutput("A_count3", sample_count, 3);
    checkOutput("A_no_overrun", overrun, 0);
    checkOutput("A_no_timeout", adc_timeout, 0);
    check_drained("A");

    $display("[TB] adc timeout");
    do_reset();
    applyStimulus(2, 4, 8'h33);
    run_until(30);
    adc_delay = -1;
    run_until(47);
    checkOutput("B_timeout_early", adc_timeout, 0);
    run_until(48);
    checkOutput("B_timeout_set", adc_timeout, 1);
    checkOutput("B_idle_after_timeout", busy, 0);
    run_until(50);
    checkOutput("B_cur_vd_kept", bus.cur_vd, 8'h33);
    checkOutput("B_calc_count", n_calc, 1);
    checkOutput("B_pid_count", n_pid, 1);
    checkOutput("B_dac_count", n_dac, 1);
    adc_delay = 3;
    run_until(75);
    check_starts("B", 20, 40, 60);
    checkOutput("B_dac_count2", n_dac, 2);
    checkOutput("B_count2", sample_count, 2);
    checkOutput("B_timeout_sticky", adc_timeout, 1);
    run_until(76);
    clr_flags = 1'b1;
    run_until(77);
    clr_flags = 1'b0;
    checkOutput("B_timeout_cleared", adc_timeout, 0);
    check_drained("B");

    $display("[TB] overrun and clear priority");
    do_reset();
    applyStimulus(2, 30, 8'h81);
    run_until(39);
    checkOutput("C_overrun_early", overrun, 0);
    run_until(40);
    checkOutput("C_overrun_set", overrun, 1);
    run_until(50);
    checkOutput("C_busy_pid_wait", busy, 1);
    run_until(59);
    checkOutput("C_one_dac", n_dac, 1);
    run_until(60);
    check_starts("C", 20, 60, -1);
    run_until(70);
    clr_flags = 1'b1;
    run_until(71);
    clr_flags = 1'b0;
    checkOutput("C_overrun_cleared", overrun, 0);
    run_until(79);
    clr_flags = 1'b1;
    run_until(80);
    checkOutput("C_set_beats_clear", overrun, 1);
    run_until(81);
    clr_flags = 1'b0;
    checkOutput("C_clear_alone", overrun, 0);
    run_until(96);
    checkOutput("C_dac_count", n_dac, 2);
    checkOutput("C_count2", sample_count, 2);
    check_drained("C");

    $display("[TB] reset during adc wait");
    do_reset();
    applyStimulus(3, 4, 8'hA5);
    run_until(23);
    rst = 1'b1;
    flush_model();
    start_cycles.push_back(20);
    step();
    checkOutput("D_cur_vd_zero", bus.cur_vd, 0);
    checkOutput("D_no_calc", bus.calc_error, 0);
    checkOutput("D_idle", busy, 0);
    checkOutput("D_count_zero", sample_count, 0);
    rst = 1'b0;
    run_until(56);
    check_starts("D", 20, 44, -1);
    checkOutput("D_count1", sample_count, 1);
    check_drained("D");

    $display("[TB] enable dropped mid iteration");
    do_reset();
    applyStimulus(3, 4, 8'h77);
    run_until(21);
    enable = 1'b0;
    run_until(95);
    check_starts("E", 20, -1, -1);
    checkOutput("E_dac_count", n_dac, 1);
    checkOutput("E_count1", sample_count, 1);
    checkOutput("E_idle", busy, 0);
    check_drained("E");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
